tb_rst_seq: RTL and testbench



---
 rtl/tb_rst_seq.sv | 175 +++++++++++++++++
 tb/tb_tb_rst_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tb_rst_seq.sv
// rtl/tb_rst_seq.sv - staged DUT reset / start / timeout sequencer (optional TB_RST_SEQ_WATCHDOG_EN)
module tb_rst_seq #(
    parameter int POR_CYCLES = 16,
    parameter int NUM_STAGES = 3,
    parameter int STAGE_GAP  = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  done,
    output logic [NUM_STAGES-1:0] dut_rst_n,
    output logic                  start,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [CNT_W-1:0]      cycle_cnt
);

    typedef enum logic [2:0] {
        S_POR   = 3'd0,
        S_REL   = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_PASS  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    localparam int TMR_MAX = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STG_W   = $clog2(NUM_STAGES + 1);

    state_t                  state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [STG_W-1:0]        stg_q, stg_d;
    logic [NUM_STAGES-1:0]   dut_rst_q, dut_rst_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    pass_q, pass_d;
    logic                    fail_q, fail_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    por_hit;
    logic                    gap_hit;
    logic                    all_rel;
    logic                    to_hit;
    logic [CNT_W-1:0]        cnt_inc;

    assign por_hit = (tmr_q == TMR_W'(POR_CYCLES - 1));
    assign gap_hit = (tmr_q == TMR_W'(STAGE_GAP - 1));
    assign all_rel = (stg_q == STG_W'(NUM_STAGES));
    // Saturating increment so a stuck DUT never wraps the count back to small values.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
`ifdef TB_RST_SEQ_WATCHDOG_EN
    // >= rather than == so a TIMEOUT already passed in the START cycle still trips.
    assign to_hit  = (cnt_inc >= CNT_W'(TIMEOUT));
`else
    assign to_hit  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_POR;
        else        state_q <= state_d;
    end

    // Next-state decode; done only matters in RUN and restart only in the terminal states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_POR:   if (por_hit) state_d = S_REL;
            S_REL:   if (gap_hit && all_rel) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (done)        state_d = S_PASS;
                else if (to_hit) state_d = S_FAIL;
            end
            S_PASS, S_FAIL: if (restart) state_d = S_POR;
            default: state_d = S_POR;
        endcase
    end

    // Next values of the registered outputs and the interval timer
    always_comb begin
        tmr_d     = tmr_q;
        stg_d     = stg_q;
        dut_rst_d = dut_rst_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_POR: begin
                busy_d = 1'b1;
                if (por_hit) begin
                    tmr_d     = '0;
                    dut_rst_d = dut_rst_q | NUM_STAGES'(1);
                    stg_d     = STG_W'(1);
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_REL: begin
                if (gap_hit) begin
                    tmr_d = '0;
                    if (all_rel) begin
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        dut_rst_d = dut_rst_q | (NUM_STAGES'(1) << stg_q);
                        stg_d     = stg_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_START: cnt_d = cnt_inc;
            S_RUN: begin
                cnt_d = cnt_inc;
                if (done) begin
                    pass_d = 1'b1;
                    busy_d = 1'b0;
                end else if (to_hit) begin
                    fail_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_PASS, S_FAIL: begin
                // cycle_cnt deliberately kept so the last result stays readable until START.
                if (restart) begin
                    dut_rst_d = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    busy_d    = 1'b1;
                    tmr_d     = '0;
                    stg_d     = '0;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_q     <= '0;
            stg_q     <= '0;
            dut_rst_q <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            tmr_q     <= tmr_d;
            stg_q     <= stg_d;
            dut_rst_q <= dut_rst_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dut_rst_n = dut_rst_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_tb_rst_seq.sv
// tb/tb_tb_rst_seq.sv - directed self-checking bench for tb_rst_seq
module tb_tb_rst_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        done = 1'b0;
    logic [2:0]  dut_rst_n;
    logic        start;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [31:0] cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int ec = 0;

    tb_rst_seq #(
        .POR_CYCLES(16),
        .NUM_STAGES(3),
        .STAGE_GAP (4),
        .TIMEOUT   (64),
        .CNT_W     (32)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .done     (done),
        .dut_rst_n(dut_rst_n),
        .start    (start),
        .busy     (busy),
        .pass     (pass),
        .fail     (fail),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, ec, obs, exp);
        end
    endtask

    // Hand table of the release staircase: 16, 20, 24.
    function automatic logic [2:0] exp_dut(input int k);
        if (k >= 24)      return 3'b111;
        else if (k >= 20) return 3'b011;
        else if (k >= 16) return 3'b001;
        else              return 3'b000;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut"},   64'(dut_rst_n), 64'd0);
        chk({tag, "_start"}, 64'(start),     64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_pass"},  64'(pass),      64'd0);
        chk({tag, "_fail"},  64'(fail),      64'd0);
        chk({tag, "_cnt"},   64'(cycle_cnt), 64'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_reset_vals("rst");

        // Default run; done pulses at 10 and 29 must be ignored, done at 40 passes
        rst_n = 1'b1;
        ec = 0;
        for (int k = 1; k <= 40; k++) begin
            done = (k == 10) || (k == 29) || (k == 40);
            tick();
            chk("a_dut",   64'(dut_rst_n), 64'(exp_dut(k)));
            chk("a_start", 64'(start),     64'(k == 28));
            chk("a_busy",  64'(busy),      64'(k < 40));
            chk("a_pass",  64'(pass),      64'(k == 40));
            chk("a_fail",  64'(fail),      64'd0);
        end
        done = 1'b0;
        chk("a_cnt12", 64'(cycle_cnt), 64'd12);

        // PASS holds
        for (int k = 41; k <= 49; k++) begin
            tick();
            chk("hold_pass", 64'(pass),      64'd1);
            chk("hold_cnt",  64'(cycle_cnt), 64'd12);
            chk("hold_dut",  64'(dut_rst_n), 64'd7);
        end

        // Restart at edge 50
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_dut",  64'(dut_rst_n), 64'd0);
        chk("rs_pass", 64'(pass),      64'd0);
        chk("rs_busy", 64'(busy),      64'd1);
        chk("rs_cnt",  64'(cycle_cnt), 64'd12);
        for (int r = 1; r <= 28; r++) begin
            tick();
            chk("rs_dut_r",   64'(dut_rst_n), 64'(exp_dut(r)));
            chk("rs_start_r", 64'(start),     64'(r == 28));
            chk("rs_cnt_r",   64'(cycle_cnt), (r == 28) ? 64'd0 : 64'd12);
            chk("rs_busy_r",  64'(busy),      64'd1);
        end

        // No done after restart: timeout behaviour (start was after edge 78 absolute)
        for (int r = 29; r <= 92; r++) begin
            tick();
            if (r == 91) begin
                chk("to_cnt63",  64'(cycle_cnt), 64'd63);
                chk("to_fail91", 64'(fail),      64'd0);
            end
        end
        chk("to_cnt64", 64'(cycle_cnt), 64'd64);
        chk("to_pass",  64'(pass),      64'd0);
`ifdef TB_RST_SEQ_WATCHDOG_EN
        chk("to_fail", 64'(fail), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        done = 1'b1;
        for (int r = 0; r < 6; r++) tick();
        done = 1'b0;
        chk("to_frozen",   64'(cycle_cnt), 64'd64);
        chk("to_fail_hld", 64'(fail),      64'd1);
        chk("to_no_pass",  64'(pass),      64'd0);
`else
        chk("nwd_fail", 64'(fail), 64'd0);
        chk("nwd_busy", 64'(busy), 64'd1);
        for (int r = 0; r < 6; r++) tick();
        chk("nwd_cnt70", 64'(cycle_cnt), 64'd70);
        chk("nwd_fail2", 64'(fail),      64'd0);
`endif

        // done on the edge where cycle_cnt reaches TIMEOUT: done wins
        rst_n = 1'b0;
        tick();
        chk_reset_vals("rst2");
        rst_n = 1'b1;
        ec = 0;
        for (int k = 1; k <= 92; k++) begin
            done = (k == 92);
            tick();
        end
        done = 1'b0;
        chk("tie_pass", 64'(pass),      64'd1);
        chk("tie_fail", 64'(fail),      64'd0);
        chk("tie_busy", 64'(busy),      64'd0);
        chk("tie_cnt",  64'(cycle_cnt), 64'd64);

        // Reset asserted at edge 22 (mid-REL), then a full replay
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ec = 0;
        for (int k = 1; k <= 21; k++) tick();
        chk("mid_dut21", 64'(dut_rst_n), 64'd3);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("mid");
        rst_n = 1'b1;
        ec = 0;
        for (int k = 1; k <= 28; k++) begin
            restart = (k == 5);
            tick();
            chk("mr_dut",   64'(dut_rst_n), 64'(exp_dut(k)));
            chk("mr_start", 64'(start),     64'(k == 28));
            chk("mr_busy",  64'(busy),      64'd1);
        end
        restart = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
